// File: rtl/rand_delay_ctrl.sv
// rand_delay_ctrl: reaction-timer control stage.
// A start pulse arms a pseudo-random wait. When the wait expires the stimulus LED
// lights and the downstream millisecond counter is enabled. The stage then measures
// the response in milliseconds until a stop pulse arrives or the response window
// closes, and holds the result for display.
//
// Optional feature: define CHEAT_DETECT_EN to end the trial when stop arrives during
// the random wait. In that case react_ms is 9999 and cheat is set. Without the macro,
// a stop during the wait is ignored and cheat is constant 0.
module rand_delay_ctrl #(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          TICK_DIV     = CLK_HZ / 1000,
    parameter int          MIN_DELAY_MS = 2000,
    parameter int          MAX_DELAY_MS = 15000,
    parameter int          TIMEOUT_MS   = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    output logic        led_stim,
    output logic        count_en,
    output logic [13:0] react_ms,
    output logic        done,
    output logic        cheat,
    output logic        timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [14:0]   MIN_DELAY  = 15'(MIN_DELAY_MS);
    localparam logic [14:0]   MAX_DELAY  = 15'(MAX_DELAY_MS);
    localparam logic [13:0]   TIMEOUT_V  = 14'(TIMEOUT_MS);
    localparam logic [13:0]   CHEAT_CODE = 14'd9999;

`ifdef CHEAT_DETECT_EN
    localparam logic CHEAT_EN = 1'b1;
`else
    localparam logic CHEAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One step of the 16-bit Fibonacci LFSR, taps 16/14/13/11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    state_t        state_r;
    logic [15:0]   lfsr_r;
    logic [PW-1:0] presc_r;
    logic [13:0]   delay_r;
    logic [13:0]   react_r;
    logic          led_r;
    logic          en_r;
    logic          done_r;
    logic          cheat_r;
    logic          timeout_r;

    logic          tick_s;
    logic [14:0]   delay_sum_s;
    logic [13:0]   load_delay_s;
    logic [13:0]   react_inc_s;

    // Millisecond tick, next reaction count and the saturated random delay to load.
    always_comb begin
        tick_s       = 1'b0;
        delay_sum_s  = MIN_DELAY + {2'b00, lfsr_r[12:0]};
        load_delay_s = 14'd0;
        react_inc_s  = react_r + 14'd1;
        if (presc_r == TICK_LAST) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (delay_sum_s > MAX_DELAY) begin
            load_delay_s = MAX_DELAY[13:0];
        end else begin
            load_delay_s = delay_sum_s[13:0];
        end
    end

    // Trial state machine with the LFSR, prescaler, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= LFSR_SEED;
            presc_r   <= {PW{1'b0}};
            delay_r   <= 14'd0;
            react_r   <= 14'd0;
            led_r     <= 1'b0;
            en_r      <= 1'b0;
            done_r    <= 1'b0;
            cheat_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            // The LFSR free-runs so the delay depends on when start is pressed.
            lfsr_r <= lfsr_step(lfsr_r);
            if (clear) begin
                state_r   <= ST_IDLE;
                presc_r   <= {PW{1'b0}};
                delay_r   <= 14'd0;
                react_r   <= 14'd0;
                led_r     <= 1'b0;
                en_r      <= 1'b0;
                done_r    <= 1'b0;
                cheat_r   <= 1'b0;
                timeout_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        // A new trial starts the same way from IDLE or from a held result.
                        if (start) begin
                            state_r   <= ST_WAIT;
                            presc_r   <= {PW{1'b0}};
                            delay_r   <= load_delay_s;
                            react_r   <= 14'd0;
                            done_r    <= 1'b0;
                            cheat_r   <= 1'b0;
                            timeout_r <= 1'b0;
                        end else begin
                            presc_r <= {PW{1'b0}};
                        end
                    end
                    ST_WAIT: begin
                        if (stop && CHEAT_EN) begin
                            state_r <= ST_DONE;
                            presc_r <= {PW{1'b0}};
                            delay_r <= 14'd0;
                            react_r <= CHEAT_CODE;
                            done_r  <= 1'b1;
                            cheat_r <= 1'b1;
                        end else if (tick_s) begin
                            presc_r <= {PW{1'b0}};
                            // A zero delay is treated like one so the counter never wraps.
                            if (delay_r <= 14'd1) begin
                                state_r <= ST_RUN;
                                delay_r <= 14'd0;
                                react_r <= 14'd0;
                                led_r   <= 1'b1;
                                en_r    <= 1'b1;
                            end else begin
                                delay_r <= delay_r - 14'd1;
                            end
                        end else begin
                            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_RUN: begin
                        // Stop wins over a coincident tick, so that tick is not counted.
                        if (stop) begin
                            state_r <= ST_DONE;
                            presc_r <= {PW{1'b0}};
                            led_r   <= 1'b0;
                            en_r    <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (tick_s) begin
                            presc_r <= {PW{1'b0}};
                            if (react_inc_s >= TIMEOUT_V) begin
                                state_r   <= ST_DONE;
                                react_r   <= TIMEOUT_V;
                                led_r     <= 1'b0;
                                en_r      <= 1'b0;
                                done_r    <= 1'b1;
                                timeout_r <= 1'b1;
                            end else begin
                                react_r <= react_inc_s;
                            end
                        end else begin
                            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        presc_r <= {PW{1'b0}};
                        led_r   <= 1'b0;
                        en_r    <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign led_stim = led_r;
    assign count_en = en_r;
    assign react_ms = react_r;
    assign done     = done_r;
    assign cheat    = cheat_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_rand_delay_ctrl.sv
// Self-checking bench for rand_delay_ctrl. Expected results go into a scoreboard
// queue when the stimulus is driven. They are popped and compared when the DUT
// presents a held result. A second instance checks the random delay load.
module tb_rand_delay_ctrl;

    typedef struct packed {
        logic [13:0] react;
        logic        cheat;
        logic        timeout;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        led_stim, count_en, done, cheat, timeout;
    logic [13:0] react_ms;

    logic        r_clear = 1'b0;
    logic        r_start = 1'b0;
    logic        r_stop = 1'b0;
    logic        r_led, r_en, r_done, r_cheat, r_timeout;
    logic [13:0] r_react;

    logic [15:0] m_lfsr;
    res_t        sb_q[$];
    logic [13:0] dq[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    rand_delay_ctrl #(
        .CLK_HZ(10_000), .TICK_DIV(10), .MIN_DELAY_MS(5), .MAX_DELAY_MS(5),
        .TIMEOUT_MS(20), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop),
        .led_stim(led_stim), .count_en(count_en), .react_ms(react_ms),
        .done(done), .cheat(cheat), .timeout(timeout)
    );

    rand_delay_ctrl #(
        .CLK_HZ(2_000), .TICK_DIV(2), .MIN_DELAY_MS(2000), .MAX_DELAY_MS(15000),
        .TIMEOUT_MS(20), .LFSR_SEED(16'hACE1)
    ) dut_rnd (
        .clk(clk), .rst_n(rst_n), .clear(r_clear), .start(r_start), .stop(r_stop),
        .led_stim(r_led), .count_en(r_en), .react_ms(r_react),
        .done(r_done), .cheat(r_cheat), .timeout(r_timeout)
    );

    // Reference LFSR, x^16+x^14+x^13+x^11+1, stepped once per clock like the DUT's.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= (m_lfsr >> 1) |
                      16'((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
        end
    end

    task automatic wait_led(output int n);
        n = 0;
        while (led_stim !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({led_stim, count_en, done, cheat, timeout, react_ms} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %b/%0d, want all zero", {led_stim, count_en, done, cheat, timeout}, react_ms);
        end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        n_cmp++;
        if ({led_stim, count_en, done, cheat, timeout, react_ms} !== 19'd0) begin
            n_bad++;
            $display("FAIL idle_50: got %b/%0d, want all zero", {led_stim, count_en, done, cheat, timeout}, react_ms);
        end
    endtask

    task automatic test_normal_trial;
        int   n;
        res_t exp_r, got_r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_led(n);
        n_cmp++;
        if (n !== 50 || count_en !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_rise: got %0d cycles en=%b, want 50 en=1", n, count_en);
        end
        repeat (72) @(negedge clk);
        stop = 1'b1;
        sb_q.push_back('{react: 14'd7, cheat: 1'b0, timeout: 1'b0});
        @(negedge clk);
        stop = 1'b0;
        wait_done(n);
        n_cmp++;
        if (n !== 0) begin
            n_bad++;
            $display("FAIL normal_done_lat: got %0d, want 0", n);
        end
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        got_r = '{react: react_ms, cheat: cheat, timeout: timeout};
        n_cmp++;
        if (got_r !== exp_r || led_stim !== 1'b0 || count_en !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_result: got react=%0d ch=%b to=%b led=%b, want react=%0d ch=%b to=%b led=0",
                     react_ms, cheat, timeout, led_stim, exp_r.react, exp_r.cheat, exp_r.timeout);
        end
    endtask

    task automatic test_timeout;
        int   n;
        res_t exp_r, got_r;
        start = 1'b1;
        sb_q.push_back('{react: 14'd20, cheat: 1'b0, timeout: 1'b1});
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_done_clr: got %b, want 0", done);
        end
        wait_led(n);
        n_cmp++;
        if (n !== 50) begin
            n_bad++;
            $display("FAIL timeout_rise: got %0d, want 50", n);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 200) begin
            n_bad++;
            $display("FAIL timeout_lat: got %0d, want 200", n);
        end
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        got_r = '{react: react_ms, cheat: cheat, timeout: timeout};
        n_cmp++;
        if (got_r !== exp_r || led_stim !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_result: got react=%0d ch=%b to=%b led=%b, want react=%0d ch=%b to=%b led=0",
                     react_ms, cheat, timeout, led_stim, exp_r.react, exp_r.cheat, exp_r.timeout);
        end
    endtask

    task automatic test_cheat;
        int   n;
        logic seen_led;
        res_t exp_r, got_r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        stop = 1'b1;
`ifdef CHEAT_DETECT_EN
        sb_q.push_back('{react: 14'd9999, cheat: 1'b1, timeout: 1'b0});
`else
        sb_q.push_back('{react: 14'd20, cheat: 1'b0, timeout: 1'b1});
`endif
        @(negedge clk);
        stop = 1'b0;
`ifdef CHEAT_DETECT_EN
        seen_led = 1'b0;
        wait_done(n);
        n_cmp++;
        if (n !== 0) begin
            n_bad++;
            $display("FAIL cheat_lat: got %0d, want 0", n);
        end
        for (int i = 0; i < 60; i++) begin
            seen_led = seen_led | led_stim;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_led !== 1'b0) begin
            n_bad++;
            $display("FAIL cheat_led: got %b, want 0", seen_led);
        end
`else
        seen_led = led_stim;
        n_cmp++;
        if (seen_led !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL cheat_ignored: got led=%b done=%b, want 0 0", seen_led, done);
        end
        wait_led(n);
        n_cmp++;
        if (n !== 30) begin
            n_bad++;
            $display("FAIL nocheat_rise: got %0d, want 30", n);
        end
        wait_done(n);
        n_cmp++;
        if (n !== 200) begin
            n_bad++;
            $display("FAIL nocheat_lat: got %0d, want 200", n);
        end
`endif
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        got_r = '{react: react_ms, cheat: cheat, timeout: timeout};
        n_cmp++;
        if (got_r !== exp_r || done !== 1'b1) begin
            n_bad++;
            $display("FAIL cheat_result: got react=%0d ch=%b to=%b done=%b, want react=%0d ch=%b to=%b done=1",
                     react_ms, cheat, timeout, done, exp_r.react, exp_r.cheat, exp_r.timeout);
        end
    endtask

    task automatic test_priority_clear;
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_led(n);
        n_cmp++;
        if (n !== 50) begin
            n_bad++;
            $display("FAIL prio_rise: got %0d, want 50", n);
        end
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (react_ms !== 14'd3 || led_stim !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL run_start_ignored: got react=%0d led=%b done=%b, want 3 1 0", react_ms, led_stim, done);
        end
        clear = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        stop = 1'b0;
        n_cmp++;
        if ({led_stim, count_en, done, cheat, timeout, react_ms} !== 19'd0) begin
            n_bad++;
            $display("FAIL clear_stop: got %b/%0d, want all zero", {led_stim, count_en, done, cheat, timeout}, react_ms);
        end
        repeat (80) @(negedge clk);
        n_cmp++;
        if ({led_stim, count_en, done, react_ms} !== 17'd0) begin
            n_bad++;
            $display("FAIL clear_idle: got %b/%0d, want all zero", {led_stim, count_en, done}, react_ms);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_led(n);
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({led_stim, count_en, done, cheat, timeout, react_ms} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %b/%0d, want all zero", {led_stim, count_en, done, cheat, timeout}, react_ms);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++;
        if ({led_stim, count_en, done, react_ms} !== 17'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b/%0d, want all zero", {led_stim, count_en, done}, react_ms);
        end
    endtask

    task automatic test_random_range;
        int          sum;
        logic [13:0] exp_d;
        for (int t = 0; t < 20; t++) begin
            sum = 2000 + int'(m_lfsr[12:0]);
            if (sum > 15000) sum = 15000;
            dq.push_back(14'(sum));
            r_start = 1'b1;
            @(negedge clk);
            r_start = 1'b0;
            exp_d = (dq.size() > 0) ? dq.pop_front() : 14'h3FFF;
            n_cmp++;
            if (dut_rnd.delay_r !== exp_d || dut_rnd.delay_r > 14'd10191) begin
                n_bad++;
                $display("FAIL rand_load[%0d]: got %0d, want %0d (max 10191)", t, dut_rnd.delay_r, exp_d);
            end
            r_clear = 1'b1;
            @(negedge clk);
            r_clear = 1'b0;
            repeat ($urandom_range(1, 7)) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_normal_trial();
        test_timeout();
        test_cheat();
        test_priority_clear();
        test_reset_mid_run();
        test_random_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
